// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : Fetch-side and execute-side handshake/payload bundle of decode_stage.
//            slave = decode stage view, master = surrounding pipeline view.
//            DECODE_ILLEGAL_TRAP_EN adds illegal_instruction.
// Revision : 1.0
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_instruction;
    logic [XLEN-1:0] fetch_pc;
    logic            flush;
    logic            execute_valid;
    logic            execute_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic            alu_branch_enable;
    logic            alu_unconditional_jalr_enable;
    logic            alu_unconditional_jal_enable;
    logic            alu_upper_immediate_lui_enable;
    logic            alu_upper_immediate_auipc_enable;
    logic            alu_register_immediate_enable;
    logic            alu_register_register_enable;
    logic [4:0]      rs1_select;
    logic [4:0]      rs2_select;
    logic [4:0]      rd_select;
    logic [XLEN-1:0] immediate;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            illegal_instruction;
`endif

    modport slave (
        input  fetch_valid, fetch_instruction, fetch_pc, flush, execute_ready,
        output fetch_ready, execute_valid, instruction, pc,
               alu_branch_enable, alu_unconditional_jalr_enable,
               alu_unconditional_jal_enable, alu_upper_immediate_lui_enable,
               alu_upper_immediate_auipc_enable, alu_register_immediate_enable,
               alu_register_register_enable, rs1_select, rs2_select, rd_select,
               immediate
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output illegal_instruction
`endif
    );

    modport master (
        output fetch_valid, fetch_instruction, fetch_pc, flush, execute_ready,
        input  fetch_ready, execute_valid, instruction, pc,
               alu_branch_enable, alu_unconditional_jalr_enable,
               alu_unconditional_jal_enable, alu_upper_immediate_lui_enable,
               alu_upper_immediate_auipc_enable, alu_register_immediate_enable,
               alu_register_register_enable, rs1_select, rs2_select, rd_select,
               immediate
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input illegal_instruction
`endif
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I decode stage; output register plus skid register so that
//            fetch_ready is a flop. Macro DECODE_ILLEGAL_TRAP_EN adds the
//            illegal_instruction output.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic     clock,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

    localparam logic [6:0] c_op_branch    = 7'b1100011;
    localparam logic [6:0] c_op_jalr      = 7'b1100111;
    localparam logic [6:0] c_op_jal       = 7'b1101111;
    localparam logic [6:0] c_op_lui       = 7'b0110111;
    localparam logic [6:0] c_op_auipc     = 7'b0010111;
    localparam logic [6:0] c_op_reg_imm   = 7'b0010011;
    localparam logic [6:0] c_op_reg_reg   = 7'b0110011;
    localparam logic [6:0] c_funct7_base  = 7'b0000000;
    localparam logic [6:0] c_funct7_alt   = 7'b0100000;

    localparam int c_en_branch  = 6;
    localparam int c_en_jalr    = 5;
    localparam int c_en_jal     = 4;
    localparam int c_en_lui     = 3;
    localparam int c_en_auipc   = 2;
    localparam int c_en_reg_imm = 1;
    localparam int c_en_reg_reg = 0;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic [6:0]      enables;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
        logic [XLEN-1:0] immediate;
    } entry_t;

    // Empty slot: what the outputs show whenever execute_valid is low.
    function automatic entry_t f_bubble();
        entry_t e;
        e    = '0;
        e.pc = RESET_PC;
        return e;
    endfunction

    function automatic entry_t f_decode(input logic [XLEN-1:0] i, input logic [XLEN-1:0] p);
        entry_t e;
        logic   legal;
        e             = '0;
        legal         = 1'b1;
        e.instruction = i;
        e.pc          = p;
        e.rs1         = i[19:15];
        e.rs2         = i[24:20];
        e.rd          = i[11:7];
        // Every listed opcode ends in 2'b11, so the compressed-encoding check is implicit.
        case (i[6:0])
            c_op_branch: begin
                e.enables[c_en_branch] = 1'b1;
                e.immediate = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            c_op_jalr: begin
                e.enables[c_en_jalr] = 1'b1;
                e.immediate = {{20{i[31]}}, i[31:20]};
            end
            c_op_jal: begin
                e.enables[c_en_jal] = 1'b1;
                e.immediate = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            c_op_lui: begin
                e.enables[c_en_lui] = 1'b1;
                e.immediate = {i[31:12], 12'b0};
            end
            c_op_auipc: begin
                e.enables[c_en_auipc] = 1'b1;
                e.immediate = {i[31:12], 12'b0};
            end
            c_op_reg_imm: begin
                e.enables[c_en_reg_imm] = 1'b1;
                e.immediate = {{20{i[31]}}, i[31:20]};
            end
            c_op_reg_reg: begin
                e.enables[c_en_reg_reg] = 1'b1;
                legal = (i[31:25] == c_funct7_base) || (i[31:25] == c_funct7_alt);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.enables   = '0;
            e.immediate = '0;
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.illegal = !legal;
`endif
        return e;
    endfunction

    entry_t out_q, out_d, skid_q, skid_d, w_fetch_entry;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   fetch_ready_q, fetch_ready_d;
    logic   w_xfer, w_consume;

    always_comb begin
        w_fetch_entry = f_decode(bus.fetch_instruction, bus.fetch_pc);
        w_xfer        = bus.fetch_valid & fetch_ready_q;
        w_consume     = out_valid_q & bus.execute_ready;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        skid_d        = skid_q;
        skid_valid_d  = skid_valid_q;

        if (bus.flush) begin
            out_d        = f_bubble();
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || w_consume) begin
            // A valid skid entry is always older than anything fetch could offer.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_xfer) begin
                out_d       = w_fetch_entry;
                out_valid_d = 1'b1;
            end else begin
                out_d       = f_bubble();
                out_valid_d = 1'b0;
            end
        end else if (w_xfer) begin
            skid_d       = w_fetch_entry;
            skid_valid_d = 1'b1;
        end

        fetch_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q         <= f_bubble();
            out_valid_q   <= 1'b0;
            skid_q        <= f_bubble();
            skid_valid_q  <= 1'b0;
            fetch_ready_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
            fetch_ready_q <= fetch_ready_d;
        end
    end

    assign bus.fetch_ready                      = fetch_ready_q;
    assign bus.execute_valid                    = out_valid_q;
    assign bus.instruction                      = out_q.instruction;
    assign bus.pc                               = out_q.pc;
    assign bus.alu_branch_enable                = out_q.enables[c_en_branch];
    assign bus.alu_unconditional_jalr_enable    = out_q.enables[c_en_jalr];
    assign bus.alu_unconditional_jal_enable     = out_q.enables[c_en_jal];
    assign bus.alu_upper_immediate_lui_enable   = out_q.enables[c_en_lui];
    assign bus.alu_upper_immediate_auipc_enable = out_q.enables[c_en_auipc];
    assign bus.alu_register_immediate_enable    = out_q.enables[c_en_reg_imm];
    assign bus.alu_register_register_enable     = out_q.enables[c_en_reg_reg];
    assign bus.rs1_select                       = out_q.rs1;
    assign bus.rs2_select                       = out_q.rs2;
    assign bus.rd_select                        = out_q.rd;
    assign bus.immediate                        = out_q.immediate;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.illegal_instruction              = out_q.illegal;
`endif

endmodule

`default_nettype wire
